pwm_multi_ch: RTL and testbench
===============================

# pwm_multi_ch

Parametrised multi-channel PWM generator with a programmable period, per-channel duty compare, and duty clamping to fixed lower and upper bounds. It also emits lower-bound and upper-bound reference pulses. A period-boundary update mechanism loads new duty and period values without glitching. It sits between the register/switch front end and the LED/actuator drivers.

## Interface
Parameters:
- CBITS, 11, counter, period and duty width
- NCH, 4, number of PWM channels
- LB_DUTY, 64, minimum effective duty; also the threshold for lb_pulse
- UB_DUTY, 1984, maximum effective duty; also the threshold for ub_pulse
- RST_PERIOD, 0, period after reset (0 means 2^CBITS)

Ports:
- clk  in  1  single clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- load_i  in  1  single-cycle strobe that captures duty_i and period_i
- duty_i  in  NCH*CBITS  requested duties; channel k is bits [k*CBITS +: CBITS]
- period_i  in  CBITS  requested period in cycles (0 means 2^CBITS)
- pulse_o  out  NCH  PWM outputs
- lb_pulse  out  1  high while cnt < LB_DUTY
- ub_pulse  out  1  high while cnt < UB_DUTY
- wrap_o  out  1  one-cycle strobe on the last count of each period
- pending_o  out  1  a captured load is waiting for the period boundary
- upd_o  out  1  one-cycle strobe when new duty/period values take effect

## Operation
Counter:
- cnt counts 0 .. P-1, then wraps to 0.
- P = period_q, or 2^CBITS when period_q == 0.
- wrap_o is high on the cycle where cnt == P-1.

Duty clamp:
- duty_eff[k] = max(LB_DUTY, min(UB_DUTY, duty_q[k])).
- Compare is unsigned at CBITS width.

Outputs:
- pulse_o[k] is registered as (cnt < duty_eff[k]).
- If duty_eff ≥ P, the output is constant high.
- lb_pulse and ub_pulse use the same compare against the LB_DUTY and UB_DUTY constants.

Enable:
- en low: cnt is held at 0; pulse_o, lb_pulse, ub_pulse and wrap_o are forced to 0; loads are still captured.
- en rising: the period starts at cnt = 0.

Reset values:
- cnt = 0, period_q = RST_PERIOD, duty_q[*] = LB_DUTY.
- All outputs 0; pending cleared.
- Reset mid-period aborts the period and discards any pending load.

## Timing
- Outputs lag the counter by 1 cycle: cnt value n produces its compare result on the following edge.
- The first high pulse_o appears on the cycle after rst deasserts, with en high.
- With the feature enabled:
  - load captured at cycle t: pending_o = 1 from t+1.
  - The values apply on the wrap cycle: upd_o = 1 and cnt = 0 on the next edge with the new values.
  - pending_o clears the same cycle that upd_o is high.
- load_i while pending: the last load wins; there is a single pending slot.
- load_i coincident with wrap_o: the new values are captured and become pending; the values already pending apply at this wrap.
- Duty is sampled at the wrap boundary only, so no partial pulses are produced.

## Configuration
- PWM_SHADOW_EN defined:
  - Loads go to shadow registers and are applied only at the period boundary, as described above.
- PWM_SHADOW_EN undefined:
  - duty_q and period_q update on the edge after load_i; upd_o pulses at t+1; pending_o is tied 0.
  - If the new P ≤ current cnt, cnt wraps to 0 on the next edge, without a wrap_o strobe.

## Structure
- pwm_pkg holds:
  - default constants for CBITS, LB_DUTY, UB_DUTY;
  - a clamp function;
  - typedef duty_t = logic [CBITS-1:0].
- Sub-module pwm_ch, instantiated NCH times via generate: clamp plus registered compare for one channel.
- The top level owns the counter, the period/shadow registers and the handshake logic.

## Test plan
- Reset, en = 1, defaults: P = 2048; pulse_o[*] high for 64 cycles per period; ub_pulse high for 1984 cycles; wrap_o every 2048 cycles.
- load period 1024, duty0 = 256, duty1 = 10, duty2 = 4000: ch0 high 256 of 1024 cycles, ch1 clamped to 64, ch2 clamped to 1984 (so constant high).
- (shadow) load at cnt = 100: pending_o high until wrap; upd_o pulses at the wrap; the old period completes intact.
- Two loads within one period (duty0 = 300, then duty0 = 500): only 500 is applied; single upd_o.
- en low at cnt = 500 for 10 cycles: all outputs 0 and cnt = 0; on re-enable a fresh period starts.
- rst asserted mid-period with a load pending: next cycle all outputs 0, pending_o = 0, duty reverts to LB_DUTY.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared constants, types and the duty clamp helper for the multi-channel PWM.
// Latency: n/a (declarations only).
// Backpressure: none.
package pwm_pkg;

    localparam int CBITS_DEF   = 11;
    localparam int LB_DUTY_DEF = 64;
    localparam int UB_DUTY_DEF = 1984;

    typedef logic [CBITS_DEF-1:0] duty_t;

    // Clamp a requested duty into [lo, hi]; done at 32 bits so any CBITS fits.
    function automatic logic [31:0] clamp_duty(input logic [31:0] d,
                                               input logic [31:0] lo,
                                               input logic [31:0] hi);
        logic [31:0] r;
        r = (d > hi) ? hi : d;
        r = (r < lo) ? lo : r;
        return r;
    endfunction

endpackage

// File: rtl/pwm_ch.sv
// One PWM channel: clamps its duty and produces the registered compare output.
// Latency: pulse reflects the counter value of the previous cycle (1 cycle).
// Backpressure: none; output is forced low while en is low.
module pwm_ch
    import pwm_pkg::*;
#(
    parameter int CBITS   = CBITS_DEF,
    parameter int LB_DUTY = LB_DUTY_DEF,
    parameter int UB_DUTY = UB_DUTY_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CBITS-1:0] cnt,
    input  logic [CBITS-1:0] duty,
    output logic             pulse
);

    logic [31:0] duty_eff;

    // Effective duty after clamping to the fixed lower/upper bounds.
    always_comb begin
        duty_eff = clamp_duty(32'(duty), 32'(LB_DUTY), 32'(UB_DUTY));
    end

    // Registered unsigned compare; a duty at or above the period gives constant high.
    always_ff @(posedge clk) begin
        if (rst) begin
            pulse <= 1'b0;
        end else begin
            pulse <= en && (32'(cnt) < duty_eff);
        end
    end

endmodule

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM: shared period counter, per-channel clamped duty compare, reference pulses.
// Latency: outputs lag the counter by 1 cycle; loads apply next edge, or at the period wrap with PWM_SHADOW_EN.
// Backpressure: none; a load while one is pending overwrites it (single slot), en low holds the counter at 0.
module pwm_multi_ch
    import pwm_pkg::*;
#(
    parameter int CBITS      = CBITS_DEF,
    parameter int NCH        = 4,
    parameter int LB_DUTY    = LB_DUTY_DEF,
    parameter int UB_DUTY    = UB_DUTY_DEF,
    parameter int RST_PERIOD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load_i,
    input  logic [NCH*CBITS-1:0] duty_i,
    input  logic [CBITS-1:0]     period_i,
    output logic [NCH-1:0]       pulse_o,
    output logic                 lb_pulse,
    output logic                 ub_pulse,
    output logic                 wrap_o,
    output logic                 pending_o,
    output logic                 upd_o
);

    localparam logic [CBITS-1:0] DUTY_RST   = CBITS'(LB_DUTY);
    localparam logic [CBITS-1:0] PERIOD_RST = CBITS'(RST_PERIOD);

    logic [CBITS-1:0]           cnt;
    logic [CBITS-1:0]           period_q;
    logic [CBITS-1:0]           last_cnt;
    logic [NCH-1:0][CBITS-1:0]  duty_q;
    logic                       wrap;
    logic                       upd;

    // A period of 0 means 2^CBITS; the modular subtraction yields all-ones for it.
    assign last_cnt = period_q - CBITS'(1);
    assign wrap     = en && (cnt == last_cnt);
    assign wrap_o   = wrap;
    assign upd_o    = upd;

    // Period counter; ">=" also folds a count stranded above a shortened period back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en) begin
            cnt <= '0;
        end else if (cnt >= last_cnt) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CBITS'(1);
        end
    end

    // Reference pulses compare the counter against the fixed bounds.
    always_ff @(posedge clk) begin
        if (rst) begin
            lb_pulse <= 1'b0;
            ub_pulse <= 1'b0;
        end else begin
            lb_pulse <= en && (32'(cnt) < 32'(LB_DUTY));
            ub_pulse <= en && (32'(cnt) < 32'(UB_DUTY));
        end
    end

`ifdef PWM_SHADOW_EN
    logic                      pending;
    logic [NCH-1:0][CBITS-1:0] sh_duty;
    logic [CBITS-1:0]          sh_period;

    assign pending_o = pending;

    // Loads park in a single shadow slot; the pending values move live only at a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            upd       <= 1'b0;
            duty_q    <= {NCH{DUTY_RST}};
            period_q  <= PERIOD_RST;
            sh_duty   <= {NCH{DUTY_RST}};
            sh_period <= PERIOD_RST;
        end else begin
            upd <= wrap && pending;
            if (wrap && pending) begin
                duty_q   <= sh_duty;
                period_q <= sh_period;
            end
            if (load_i) begin
                sh_duty   <= duty_i;
                sh_period <= period_i;
                pending   <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end
`else
    assign pending_o = 1'b0;

    // Loads take effect on the very next edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd      <= 1'b0;
            duty_q   <= {NCH{DUTY_RST}};
            period_q <= PERIOD_RST;
        end else begin
            upd <= load_i;
            if (load_i) begin
                duty_q   <= duty_i;
                period_q <= period_i;
            end
        end
    end
`endif

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        pwm_ch #(
            .CBITS   (CBITS),
            .LB_DUTY (LB_DUTY),
            .UB_DUTY (UB_DUTY)
        ) u_ch (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .cnt   (cnt),
            .duty  (duty_q[k]),
            .pulse (pulse_o[k])
        );
    end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus random loads/enables against a period-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_multi_ch;

    localparam int CB = 11;
    localparam int NC = 4;
`ifdef PWM_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en = 1'b1;
    logic            load_i = 1'b0;
    logic [NC*CB-1:0] duty_i = '0;
    logic [CB-1:0]   period_i = '0;
    logic [NC-1:0]   pulse_o;
    logic            lb_pulse, ub_pulse, wrap_o, pending_o, upd_o;

    pwm_multi_ch dut (
        .clk(clk), .rst(rst), .en(en), .load_i(load_i), .duty_i(duty_i),
        .period_i(period_i), .pulse_o(pulse_o), .lb_pulse(lb_pulse),
        .ub_pulse(ub_pulse), .wrap_o(wrap_o), .pending_o(pending_o), .upd_o(upd_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int   m_cnt = 0, m_per = 0, m_pend = 0, sh_per = 0;
    int   m_duty[NC];
    int   sh_duty[NC];
    logic [NC-1:0] e_pulse = '0;
    logic e_lb = 0, e_ub = 0, e_upd = 0;

    // observed counters
    int c_p[NC];
    int c_lb, c_ub, c_wrap, c_upd, c_ticks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff(input int d);
        return (d < 64) ? 64 : ((d > 1984) ? 1984 : d);
    endfunction

    function automatic int plen(input int p);
        return (p == 0) ? 2048 : p;
    endfunction

    task automatic model_edge();
        int  p;
        logic wrap_now;
        if (rst) begin
            m_cnt = 0; m_per = 0; m_pend = 0;
            for (int k = 0; k < NC; k++) m_duty[k] = 64;
            e_pulse = '0; e_lb = 0; e_ub = 0; e_upd = 0;
        end else begin
            p = plen(m_per);
            for (int k = 0; k < NC; k++) e_pulse[k] = en && (m_cnt < eff(m_duty[k]));
            e_lb = en && (m_cnt < 64);
            e_ub = en && (m_cnt < 1984);
            wrap_now = en && (m_cnt == p - 1);
            if (SHADOW) begin
                e_upd = wrap_now && (m_pend != 0);
                if (e_upd) begin
                    m_per = sh_per;
                    for (int k = 0; k < NC; k++) m_duty[k] = sh_duty[k];
                end
                if (load_i) begin
                    sh_per = int'(period_i);
                    for (int k = 0; k < NC; k++) sh_duty[k] = int'(duty_i[k*CB +: CB]);
                    m_pend = 1;
                end else if (e_upd) begin
                    m_pend = 0;
                end
            end else begin
                e_upd = load_i;
                if (load_i) begin
                    m_per = int'(period_i);
                    for (int k = 0; k < NC; k++) m_duty[k] = int'(duty_i[k*CB +: CB]);
                end
            end
            if (!en || m_cnt >= p - 1) m_cnt = 0;
            else m_cnt = m_cnt + 1;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NC; k++) c_p[k] = 0;
        c_lb = 0; c_ub = 0; c_wrap = 0; c_upd = 0; c_ticks = 0;
    endtask

    task automatic tick();
        logic e_wrap;
        @(posedge clk);
        model_edge();
        #1;
        e_wrap = en && !rst && (m_cnt == plen(m_per) - 1);
        chk("outs", {23'b0, pulse_o, lb_pulse, ub_pulse, wrap_o, pending_o, upd_o},
                    {23'b0, e_pulse, e_lb, e_ub, e_wrap, (m_pend != 0), e_upd});
        for (int k = 0; k < NC; k++) c_p[k] += int'(pulse_o[k]);
        c_lb += int'(lb_pulse); c_ub += int'(ub_pulse); c_wrap += int'(wrap_o);
        c_upd += int'(upd_o); c_ticks++;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_load(input int d0, input int d1, input int d2, input int d3, input int p);
        duty_i   = {CB'(d3), CB'(d2), CB'(d1), CB'(d0)};
        period_i = CB'(p);
        load_i   = 1'b1;
        tick();
        load_i   = 1'b0;
    endtask

    task automatic wait_upd(input int budget);
        int i;
        i = 0;
        while (!upd_o && i < budget) begin tick(); i++; end
        chk("upd_seen", 32'(upd_o), 32'd1);
    endtask

    task automatic wait_wrap(input int budget);
        int i;
        i = 0;
        tick();
        while (!wrap_o && i < budget) begin tick(); i++; end
        chk("wrap_seen", 32'(wrap_o), 32'd1);
    endtask

    initial begin
        logic [63:0] r;
        int i;

        // reset and default period
        run_n(2);
        chk("reset_outs", {26'b0, pulse_o, lb_pulse, ub_pulse}, 32'd0);
        chk("reset_flags", {29'b0, wrap_o, pending_o, upd_o}, 32'd0);
        rst = 1'b0;
        clear_counts();
        tick();
        chk("first_pulse", 32'(pulse_o), 32'hf);
        run_n(2047);
        chk("def_p0", c_p[0], 64);
        chk("def_p3", c_p[3], 64);
        chk("def_lb", c_lb, 64);
        chk("def_ub", c_ub, 1984);
        chk("def_wrap", c_wrap, 1);

        // period 1024 with clamped duties
        do_load(256, 10, 4000, 2000, 1024);
        wait_upd(4096);
        wait_wrap(4096);
        clear_counts();
        run_n(1024);
        chk("p1k_ch0", c_p[0], 256);
        chk("p1k_ch1_lo", c_p[1], 64);
        chk("p1k_ch2_hi", c_p[2], 1024);
        chk("p1k_ch3_hi", c_p[3], 1024);
        chk("p1k_ub", c_ub, 1024);
        chk("p1k_wrap", c_wrap, 1);

        // load at cnt 100, second load overwrites the first
        run_n(101);
        chk("cnt_at_100", m_cnt, 100);
        clear_counts();
        do_load(300, 10, 4000, 2000, 1024);
        chk("pend_after_load", 32'(pending_o), 32'(SHADOW));
        run_n(9);
        do_load(500, 10, 4000, 2000, 1024);
        wait_wrap(2048);
        tick();
        chk("old_period_len", c_ticks, 924);
        chk("upd_count", c_upd, SHADOW ? 1 : 2);
        chk("pend_clear", 32'(pending_o), 32'd0);
        clear_counts();
        run_n(1024);
        chk("last_load_wins", c_p[0], 500);

        // enable dropped at cnt 500
        i = 0;
        while (m_cnt != 500 && i < 2048) begin tick(); i++; end
        chk("reach_500", m_cnt, 500);
        en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("en_low_outs", {28'b0, pulse_o} | {28'b0, lb_pulse, ub_pulse, wrap_o, 1'b0}, 32'd0);
        end
        en = 1'b1;
        clear_counts();
        run_n(1024);
        chk("reen_p0", c_p[0], 500);
        chk("reen_lb", c_lb, 64);
        chk("reen_wrap", c_wrap, 1);

        // reset mid-period with a load pending
        run_n(37);
        do_load(700, 900, 100, 1500, 300);
        chk("pend_before_rst", 32'(pending_o), 32'(SHADOW));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_outs", {23'b0, pulse_o, lb_pulse, ub_pulse, wrap_o, pending_o, upd_o}, 32'd0);
        clear_counts();
        run_n(2048);
        chk("rst_p0", c_p[0], 64);
        chk("rst_p1", c_p[1], 64);
        chk("rst_ub", c_ub, 1984);
        chk("rst_wrap", c_wrap, 1);

        // random loads, enables and resets
        for (int n = 0; n < 20000; n++) begin
            rst = ($urandom_range(0, 2999) == 0);
            if ($urandom_range(0, 399) == 0) en = ~en;
            load_i = ($urandom_range(0, 149) == 0);
            if (load_i) begin
                r = {$urandom, $urandom};
                duty_i = r[NC*CB-1:0];
                if ($urandom_range(0, 7) == 0) period_i = CB'($urandom_range(0, 2047));
                else period_i = CB'($urandom_range(1, 200));
            end
            tick();
        end
        rst = 1'b0;
        load_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
